// File: rtl/dsi_byte_repacker.sv
// Byte repacker for the DSI datapath: merges ragged input beats into
// densely packed output words with packet framing and a final flush.
module dsi_byte_repacker #(
    parameter int IN_BYTES  = 4,
    parameter int OUT_BYTES = 4,
    parameter int CNT_W     = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [8*IN_BYTES-1:0]            in_data,
    input  logic [$clog2(IN_BYTES+1)-1:0]    in_bytes,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [8*OUT_BYTES-1:0]           out_data,
    output logic [$clog2(OUT_BYTES+1)-1:0]   out_bytes,
    output logic                             out_last,
    output logic                             err_len,
    output logic [CNT_W-1:0]                 words_out
);

    localparam int ACC = IN_BYTES + OUT_BYTES;
    localparam int IBW = $clog2(IN_BYTES + 1);
    localparam int OBW = $clog2(OUT_BYTES + 1);
    localparam int FW  = $clog2(ACC + 1);

    typedef enum logic {
        ACCUM,
        FLUSH
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [8*ACC-1:0]     acc;
    logic [8*ACC-1:0]     acc_n;
    logic [8*ACC-1:0]     ins;
    logic [8*IN_BYTES-1:0] in_masked;
    logic [FW-1:0]        fill;
    logic [FW-1:0]        fill_n;
    logic [FW-1:0]        base;
    logic [FW-1:0]        in_cnt;
    logic [FW-1:0]        pop;
    logic                 accept;
    logic                 fire;
    logic                 bad_len;

    // Pop is applied before the new beat lands, so the beat goes to lane fill-pop.
    always_comb begin
        accept  = in_valid && in_ready;
        fire    = out_valid && out_ready;
        bad_len = in_bytes > IBW'(IN_BYTES);
        in_cnt  = '0;
        if (accept) begin
            in_cnt = bad_len ? FW'(IN_BYTES) : FW'(in_bytes);
        end
        pop = fire ? FW'(out_bytes) : '0;
        for (int i = 0; i < IN_BYTES; i++) begin
            in_masked[8*i +: 8] = (FW'(i) < in_cnt) ? in_data[8*i +: 8] : 8'h00;
        end
        base   = fill - pop;
        ins    = {{(8*OUT_BYTES){1'b0}}, in_masked} << {base, 3'b000};
        acc_n  = (acc >> {pop, 3'b000}) | ins;
        fill_n = base + in_cnt;

        state_n = state;
        unique case (state)
            ACCUM: begin
                if (accept && in_last) begin
                    state_n = FLUSH;
                end
            end
            FLUSH: begin
                if (fill == '0 || (fire && fill <= FW'(OUT_BYTES))) begin
                    state_n = ACCUM;
                end
            end
            default: state_n = ACCUM;
        endcase
    end

    // Outputs are registered from the next-state view so they track fill exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ACCUM;
            acc       <= '0;
            fill      <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bytes <= '0;
            out_last  <= 1'b0;
            err_len   <= 1'b0;
            words_out <= '0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            fill      <= fill_n;
            err_len   <= accept && bad_len;
            words_out <= words_out + CNT_W'(fire);
            out_data  <= acc_n[8*OUT_BYTES-1:0];
            if (state_n == ACCUM) begin
                in_ready  <= (fill_n <= FW'(OUT_BYTES));
                out_valid <= (fill_n >= FW'(OUT_BYTES));
                out_bytes <= OBW'(OUT_BYTES);
                out_last  <= 1'b0;
            end else begin
                in_ready  <= 1'b0;
                out_valid <= (fill_n != '0);
                out_bytes <= (fill_n < FW'(OUT_BYTES)) ? OBW'(fill_n)
                                                       : OBW'(OUT_BYTES);
                out_last  <= (fill_n != '0) && (fill_n <= FW'(OUT_BYTES));
            end
        end
    end

endmodule

// File: tb/tb_dsi_byte_repacker.sv
// Bench for dsi_byte_repacker: directed framing cases plus random streams
// scored against a byte-queue model, for 4->4 and 4->8 byte widths.
module tb_dsi_byte_repacker;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic [2:0]  in_bytes;
    logic        in_last;
    logic        iv0, iv1, or0, or1;
    logic        rdy0, rdy1, ov0, ov1, ol0, ol1, er0, er1;
    logic [31:0] od0;
    logic [63:0] od1;
    logic [2:0]  ob0;
    logic [3:0]  ob1;
    logic [15:0] wo0, wo1;

    int          checks = 0;
    int          failures = 0;
    int          cur = 0;
    int          exp_words = 0;
    logic [7:0]  q[$];
    bit          closed = 0;

    always #5 clk = ~clk;

    dsi_byte_repacker #(.IN_BYTES(4), .OUT_BYTES(4), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(rdy0),
        .in_data(in_data), .in_bytes(in_bytes), .in_last(in_last),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_bytes(ob0),
        .out_last(ol0), .err_len(er0), .words_out(wo0)
    );

    dsi_byte_repacker #(.IN_BYTES(4), .OUT_BYTES(8), .CNT_W(16)) u1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(rdy1),
        .in_data(in_data), .in_bytes(in_bytes), .in_last(in_last),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_bytes(ob1),
        .out_last(ol1), .err_len(er1), .words_out(wo1)
    );

    function automatic logic g_ready();
        return (cur != 0) ? rdy1 : rdy0;
    endfunction
    function automatic logic g_ivalid();
        return (cur != 0) ? iv1 : iv0;
    endfunction
    function automatic logic g_oready();
        return (cur != 0) ? or1 : or0;
    endfunction
    function automatic logic g_valid();
        return (cur != 0) ? ov1 : ov0;
    endfunction
    function automatic logic g_last();
        return (cur != 0) ? ol1 : ol0;
    endfunction
    function automatic logic g_err();
        return (cur != 0) ? er1 : er0;
    endfunction
    function automatic logic [63:0] g_data();
        return (cur != 0) ? od1 : {32'h0, od0};
    endfunction
    function automatic logic [63:0] g_bytes();
        return (cur != 0) ? 64'(ob1) : 64'(ob0);
    endfunction
    function automatic logic [63:0] g_words();
        return (cur != 0) ? 64'(wo1) : 64'(wo0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_iv(input logic v);
        if (cur != 0) iv1 = v;
        else iv0 = v;
    endtask

    task automatic set_or(input logic v);
        if (cur != 0) or1 = v;
        else or0 = v;
    endtask

    // Scoreboard: output pops come from the byte queue, accepted beats push onto it.
    logic [63:0] pd;
    logic [63:0] pb;
    logic        pl;
    bit          stalled = 0;

    always @(negedge clk) begin : mon
        int          ob;
        int          sz;
        int          n;
        int          eff;
        logic        el;
        logic [63:0] ed;
        if (reset) begin
            q.delete();
            closed  = 0;
            stalled = 0;
        end else begin
            ob = (cur != 0) ? 8 : 4;
            if (stalled) begin
                chk("hold_valid", 64'(g_valid()), 64'd1);
                chk("hold_data", g_data(), pd);
                chk("hold_bytes", g_bytes(), pb);
                chk("hold_last", 64'(g_last()), 64'(pl));
            end
            if (g_valid() && g_oready()) begin
                sz = q.size();
                n  = (sz < ob) ? sz : ob;
                el = closed && (sz <= ob);
                chk("fire_allowed", 64'((sz >= ob) || closed), 64'd1);
                ed = '0;
                for (int i = 0; i < n; i++) ed[8*i +: 8] = q.pop_front();
                chk("word_data", g_data(), ed);
                chk("word_bytes", g_bytes(), 64'(n));
                chk("word_last", 64'(g_last()), 64'(el));
                if (el) closed = 0;
            end
            stalled = g_valid() && !g_oready();
            pd = g_data();
            pb = g_bytes();
            pl = g_last();
            if (g_ivalid() && g_ready()) begin
                eff = (in_bytes > 3'd4) ? 4 : int'(in_bytes);
                for (int i = 0; i < eff; i++) q.push_back(in_data[8*i +: 8]);
                if (in_last) closed = (q.size() != 0);
            end
        end
    end

    task automatic send(input logic [31:0] d, input int nb, input bit last);
        int t;
        in_data  = d;
        in_bytes = 3'(nb);
        in_last  = last;
        set_iv(1'b1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!g_ready() && t < 200);
        chk("send_accept", 64'(g_ready()), 64'd1);
        @(posedge clk);
        #1;
        set_iv(1'b0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((g_valid() || q.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_idle", 64'(g_valid()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int which);
        reset = 1'b1;
        iv0 = 1'b0;
        iv1 = 1'b0;
        or0 = 1'b0;
        or1 = 1'b0;
        cur = which;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(g_ready()), 64'd0);
        chk("rst_out_valid", 64'(g_valid()), 64'd0);
        chk("rst_out_data", g_data(), 64'd0);
        chk("rst_out_bytes", g_bytes(), 64'd0);
        chk("rst_out_last", 64'(g_last()), 64'd0);
        chk("rst_err_len", 64'(g_err()), 64'd0);
        chk("rst_words_out", g_words(), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_release_ready", 64'(g_ready()), 64'd1);
        exp_words = 0;
    endtask

    task automatic rand_run(input int nbeats);
        bit done;
        int ob;
        done = 0;
        ob = (cur != 0) ? 8 : 4;
        fork
            begin
                int left;
                left = nbeats;
                while (left > 0) begin
                    int plen;
                    int pbytes;
                    plen   = $urandom_range(1, 6);
                    pbytes = 0;
                    if (plen > left) plen = left;
                    for (int k = 0; k < plen; k++) begin
                        bit lst;
                        int nb;
                        lst = (k == plen - 1);
                        nb  = lst ? $urandom_range(1, 4) : $urandom_range(0, 4);
                        pbytes += nb;
                        send($urandom, nb, lst);
                        if ($urandom_range(0, 3) == 0) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                    exp_words += (pbytes + ob - 1) / ob;
                    left -= plen;
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    set_or($urandom_range(0, 3) != 0);
                end
            end
        join
        set_or(1'b1);
        wait_idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_data  = '0;
        in_bytes = '0;
        in_last  = 1'b0;
        do_reset(0);

        // full beats, one cycle latency
        set_or(1'b1);
        send(32'h03020100, 4, 0);
        chk("full_w0_valid", 64'(g_valid()), 64'd1);
        chk("full_w0_data", g_data(), 64'h03020100);
        chk("full_w0_bytes", g_bytes(), 64'd4);
        send(32'h07060504, 4, 1);
        chk("full_w1_data", g_data(), 64'h07060504);
        chk("full_w1_last", 64'(g_last()), 64'd1);
        exp_words += 2;
        wait_idle();
        chk("full_words", g_words(), 64'(exp_words));

        // ragged beats across a word boundary
        send(32'h00AABBCC, 3, 0);
        send(32'h00DDEEFF, 3, 0);
        send(32'h00001122, 2, 1);
        chk("rag_w1_data", g_data(), 64'h1122DDEE);
        chk("rag_w1_last", 64'(g_last()), 64'd1);
        chk("rag_w1_bytes", g_bytes(), 64'd4);
        exp_words += 2;
        wait_idle();

        // partial flush holds off input until it drains
        send(32'h44332211, 4, 0);
        send(32'hFFFFFF55, 1, 1);
        chk("pf_data", g_data(), 64'h55);
        chk("pf_bytes", g_bytes(), 64'd1);
        chk("pf_last", 64'(g_last()), 64'd1);
        chk("pf_in_ready", 64'(g_ready()), 64'd0);
        set_or(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("pf_stall_ready", 64'(g_ready()), 64'd0);
        chk("pf_stall_valid", 64'(g_valid()), 64'd1);
        set_or(1'b1);
        @(posedge clk);
        #1;
        chk("pf_ready_back", 64'(g_ready()), 64'd1);
        chk("pf_valid_done", 64'(g_valid()), 64'd0);
        exp_words += 2;
        chk("pf_words", g_words(), 64'(exp_words));

        // backpressure for 10 cycles while streaming
        set_or(1'b0);
        fork
            begin
                repeat (10) @(posedge clk);
                #1;
                set_or(1'b1);
            end
            begin
                send($urandom, 4, 0);
                send($urandom, 4, 0);
                chk("bp_in_ready_low", 64'(g_ready()), 64'd0);
                for (int k = 0; k < 6; k++) send($urandom, 4, k == 5);
            end
        join
        exp_words += 8;
        wait_idle();
        chk("bp_words", g_words(), 64'(exp_words));

        // oversize length clamps and flags
        chk("err_idle", 64'(g_err()), 64'd0);
        send(32'hDDCCBBAA, 7, 1);
        chk("err_pulse", 64'(g_err()), 64'd1);
        chk("err_data", g_data(), 64'hDDCCBBAA);
        chk("err_bytes", g_bytes(), 64'd4);
        @(posedge clk);
        #1;
        chk("err_one_cycle", 64'(g_err()), 64'd0);
        exp_words += 1;
        wait_idle();

        // empty last beat on empty accumulator emits nothing
        send(32'hFFFFFFFF, 0, 1);
        chk("empty_valid", 64'(g_valid()), 64'd0);
        chk("empty_ready", 64'(g_ready()), 64'd0);
        @(posedge clk);
        #1;
        chk("empty_ready_back", 64'(g_ready()), 64'd1);
        send(32'hFFFFFF12, 1, 1);
        chk("mask_data", g_data(), 64'h12);
        exp_words += 1;
        wait_idle();
        chk("mid_words", g_words(), 64'(exp_words));

        // reset with bytes buffered
        send(32'h00332211, 3, 0);
        chk("pre_rst_valid", 64'(g_valid()), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(g_valid()), 64'd0);
        chk("async_rst_ready", 64'(g_ready()), 64'd0);
        chk("async_rst_words", g_words(), 64'd0);
        exp_words = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        send(32'h99887766, 4, 1);
        chk("post_rst_data", g_data(), 64'h99887766);
        chk("post_rst_last", 64'(g_last()), 64'd1);
        exp_words += 1;
        wait_idle();
        chk("post_rst_words", g_words(), 64'(exp_words));

        rand_run(300);
        chk("rand4_words", g_words(), 64'(exp_words));

        // 4-byte beats into 8-byte words
        do_reset(1);
        set_or(1'b1);
        send(32'h03020100, 4, 0);
        send(32'h07060504, 4, 0);
        chk("w8_w0_data", g_data(), 64'h0706050403020100);
        chk("w8_w0_last", 64'(g_last()), 64'd0);
        send(32'h0B0A0908, 4, 0);
        send(32'h0F0E0D0C, 4, 1);
        chk("w8_w1_data", g_data(), 64'h0F0E0D0C0B0A0908);
        chk("w8_w1_last", 64'(g_last()), 64'd1);
        exp_words += 2;
        wait_idle();
        chk("w8_words", g_words(), 64'(exp_words));

        rand_run(1000);
        chk("rand8_words", g_words(), 64'(exp_words));
        chk("rand8_queue_empty", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsi_byte_repacker.md
Name: dsi_byte_repacker

Overview:
- Parametrised successor to the fixed 32-bit offset repacker in the DSI datapath.
- Takes a stream of partially-filled input words, each carrying 0..IN_BYTES valid bytes, and emits densely packed OUT_BYTES-wide words.
- Provides valid/ready handshakes on both sides, packet framing, and a flushed final partial word.
- Sits between the pixel/command fetch logic and the DSI packet assembler.

Parameters:
- IN_BYTES, 4, byte lanes per input beat (1..16).
- OUT_BYTES, 4, byte lanes per output word (1..16); IN_BYTES and OUT_BYTES are independent.
- CNT_W, 16, width of the output word statistics counter.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block accepts the beat this cycle
- in_data  input  8*IN_BYTES  input bytes, byte 0 in bits [7:0]
- in_bytes  input  $clog2(IN_BYTES+1)  count of valid bytes, from lane 0 upward
- in_last  input  1  beat is the final beat of a packet
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accepts the word
- out_data  output  8*OUT_BYTES  packed bytes, first byte in lane 0
- out_bytes  output  $clog2(OUT_BYTES+1)  valid bytes in out_data; equals OUT_BYTES except on a last word
- out_last  output  1  final word of a packet
- err_len  output  1  one-cycle pulse when an accepted beat has in_bytes > IN_BYTES
- words_out  output  CNT_W  count of output words accepted; wraps modulo 2^CNT_W

Behaviour:
- Reset is asynchronous and active-high.
  - All internal state clears: accumulator, fill, flush flag, state, words_out.
  - Outputs in reset: in_ready=0, out_valid=0, out_data=0, out_bytes=0, out_last=0, err_len=0, words_out=0.
  - in_ready returns to 1 on the first clk edge after reset deasserts.
- Storage:
  - Byte accumulator of ACC = IN_BYTES+OUT_BYTES bytes.
  - fill counter of $clog2(ACC+1) bits, holding the count of valid bytes, which are packed from lane 0.
- Input acceptance: a beat is accepted when in_valid && in_ready.
  - Lanes at or above in_bytes are masked to zero before insertion.
  - in_bytes > IN_BYTES is clamped to IN_BYTES, and err_len pulses in the following cycle.
- Output fire: a word fires when out_valid && out_ready. The accumulator shifts down by out_bytes lanes and fill decreases by out_bytes.
- Same-cycle input accept and output fire:
  - The pop is applied first.
  - New bytes are written starting at lane (fill - popped).
  - Resulting fill = fill - popped + in_bytes.
- Latency: out_data, out_bytes, out_last and out_valid are registered. An accepted beat is visible at the output one cycle later at the earliest.
- State machine:
  - ACCUM:
    - in_ready = (fill <= OUT_BYTES).
    - out_valid = (fill >= OUT_BYTES); out_bytes = OUT_BYTES; out_last = 0.
    - An accepted beat with in_last=1 moves the block to FLUSH.
  - FLUSH:
    - in_ready = 0, so packets never merge.
    - out_valid = (fill > 0); out_bytes = min(fill, OUT_BYTES).
    - out_last = 1 only when fill <= OUT_BYTES. Unused upper lanes of out_data are zero.
    - When the last word fires, return to ACCUM with fill=0.
    - If FLUSH is entered with fill=0 (last beat with in_bytes=0 and an empty accumulator), no word is emitted and the block returns to ACCUM on the next cycle.
- Output stall: out_data, out_bytes and out_last hold stable while out_valid && !out_ready.
- words_out increments on every output fire, including last words.
- Reset mid-packet discards all buffered bytes, and no out_last is emitted.

Test Plan:
- Full beats with IN=OUT=4: in_bytes=4, data 0x03020100 then 0x07060504, out_ready=1 -> out_data 0x03020100 then 0x07060504, out_bytes=4, one cycle after each accept; words_out=2.
- Ragged packing: beats 3,3,2 bytes (0x00AABBCC, 0x00DDEEFF, 0x00001122), last on beat 3 -> words 0xFFAABBCC then 0x1122DDEE; second word has out_last=1, out_bytes=4.
- Partial flush: beats 4 (0x44332211) then 1 byte 0x55 with last -> 0x44332211, then 0x00000055 with out_bytes=1, out_last=1; in_ready stays 0 until that word fires.
- Backpressure: out_ready=0 for 10 cycles while streaming 4-byte beats -> in_ready drops once fill>4, out_data holds stable, no byte lost or duplicated after release; compare against a reference byte queue.
- Width mismatch IN=4, OUT=8: four 4-byte beats -> two 8-byte words, byte order preserved; random in_bytes 0..4 for 1000 beats matches the scoreboard.
- Errors and reset: in_bytes=7 with IN=4 -> treated as 4, err_len pulses for one cycle. Reset asserted with fill=3 -> out_valid=0 immediately; the next packet starts at lane 0.
